sm_result_packer: RTL and testbench
===================================

// Module: sm_result_packer
// PURPOSE
//  Output end of the sign-magnitude adder datapath. Converts the two's-complement sum + carry
//  from the 32-bit ripple adder back to 33-bit sign-magnitude ({sign, mag[31:0]}).
//  Detects magnitude overflow (saturates) and counts overflow events.
//  Two-stage valid/ready pipeline between the adder and the result consumer.
// PARAMETERS
//  CNT_W   16   width of saturating overflow event counter
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      sum/cout/neg_cnt valid this cycle
//  in_ready   out  1      stage 1 can accept; transfer when in_valid & in_ready
//  sum        in   32     adder Sum[31:0]
//  cout       in   1      adder carry out
//  neg_cnt    in   2      number of operands negated by control unit with nonzero magnitude (0..2)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  res        out  33     {sign, magnitude}; sign=res[32]
//  res_ovf    out  1      |result| exceeded 2^32-1; magnitude saturated
//  ovf_clr    in   1      clear overflow counter
//  ovf_cnt    out  CNT_W  saturating count of accepted results with res_ovf=1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): s1_valid, out_valid, res, res_ovf, ovf_cnt all 0. In-flight data dropped.
//   in_ready=1 in the first cycle after reset release.
//  Arithmetic: S = {2'b00,cout,sum} - neg_cnt*2^32, 35-bit signed; range -2^33 < S < 2^33.
//   neg_cnt=3 is illegal; treat as 2.
//   sign = S<0; mag = |S|. If mag > 32'hFFFF_FFFF: res_ovf=1, mag=32'hFFFF_FFFF, sign kept.
//   S==0 always gives res=33'h0 (no negative zero).
//  Stage 1 (on input transfer): register S. Stage 2: register sign, saturated mag, res_ovf.
//  Latency: input transfer at cycle N -> out_valid=1 at N+2 when no backpressure.
//   Throughput 1 result/cycle.
//  Handshake:
//   s2 advances when !out_valid | out_ready.
//   s1 advances into s2 when s1_valid & s2 advances.
//   in_ready = !s1_valid | (s2 advances); combinational from out_ready, no comb path from in_valid.
//   res/res_ovf held stable while out_valid & !out_ready. Max 2 results in flight; order preserved.
//   out_valid drops when the last result transfers and s1 is empty.
//  Counter: ovf_cnt += 1 on each output transfer (out_valid & out_ready) with res_ovf=1.
//   Saturates at all-ones (no wrap).
//   ovf_clr=1 sets ovf_cnt to 0 next cycle; clear wins over a simultaneous increment.
//   Reset also zeroes the counter.
// TESTING
//  1 sum=8,cout=0,neg=0 (5+3) -> res={0,8}, ovf=0, out_valid 2 cycles after accept.
//  2 sum=FFFFFFFE,cout=0,neg=1 (3-5) -> res={1,2}.
//    sum=0,cout=1,neg=1 (5-5) -> res=33'h0 (no -0).
//  3 sum=0,cout=1,neg=0 (FFFFFFFF+1) -> res={0,FFFFFFFF}, ovf=1, ovf_cnt 0->1.
//    sum=2,cout=0,neg=2 (-FFFFFFFF-FFFFFFFF) -> res={1,FFFFFFFF}, ovf=1.
//  4 Stream 4 results with out_ready=0 -> in_ready low after 2 accepted; res stable.
//    Release out_ready -> all 4 delivered in order, one per cycle.
//  5 Preload ovf_cnt=FFFF (CNT_W=16) + overflow transfer -> stays FFFF.
//    ovf_clr coincident with an overflow transfer -> ovf_cnt=0.
//  6 rst_n=0 with 2 results in flight -> next cycle out_valid=0, ovf_cnt=0, in_ready=1.
//    Nothing emitted after release.

Source files
------------

// File: rtl/sm_result_packer_if.sv
// Handshake bundles on either side of the result packer.
// sm_sum_if: adder -> packer (two's-complement sum, carry, negation count).
// sm_res_if: packer -> consumer (sign-magnitude result plus overflow flag).

interface sm_sum_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum;
  logic        cout;
  logic [1:0]  neg_cnt;

  // Producer side (the adder)
  modport master (output in_valid, sum, cout, neg_cnt, input in_ready);
  // Consumer side (the packer)
  modport slave  (input in_valid, sum, cout, neg_cnt, output in_ready);
endinterface

interface sm_res_if;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] res;
  logic        res_ovf;

  // Producer side (the packer)
  modport master (output out_valid, res, res_ovf, input out_ready);
  // Consumer side (the result sink)
  modport slave  (input out_valid, res, res_ovf, output out_ready);
endinterface

// File: rtl/sm_result_packer.sv
// Converts adder sum+carry back to 33-bit sign-magnitude, saturating on overflow.
// Latency 2 cycles from input transfer to out_valid; 1 result/cycle throughput.
// Backpressure: out_ready stalls stage 2, then stage 1; in_ready drops with 2 results in flight.

module sm_result_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sm_sum_if.slave          in_if,
  sm_res_if.master         out_if,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  // Stage 1: signed 35-bit sum
  logic        s1_valid_q, s1_valid_d;
  logic [34:0] s1_s_q, s1_s_d;

  // Stage 2: packed sign-magnitude result
  logic        out_valid_q, out_valid_d;
  logic [32:0] res_q, res_d;
  logic        res_ovf_q, res_ovf_d;

  // Overflow event counter
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Handshake and datapath intermediates
  logic        s2_adv;
  logic        in_fire;
  logic        out_fire;
  logic [1:0]  neg_eff;
  logic [34:0] s_in;
  logic        s_neg;
  logic [34:0] s_abs;
  logic        mag_ovf;
  logic [31:0] mag_sat;

  // Pipeline advance conditions; in_ready depends on out_ready but never on in_valid
  always_comb begin
    s2_adv   = !out_valid_q || out_if.out_ready;
    in_fire  = in_if.in_valid && (!s1_valid_q || s2_adv);
    out_fire = out_valid_q && out_if.out_ready;
  end

  assign in_if.in_ready = !s1_valid_q || s2_adv;

  // Stage 1 arithmetic: {cout,sum} minus one 2^32 per negated operand; code 3 behaves as 2
  always_comb begin
    neg_eff = (in_if.neg_cnt == 2'd3) ? 2'd2 : in_if.neg_cnt;
    s_in    = {2'b00, in_if.cout, in_if.sum} - {1'b0, neg_eff, 32'h0000_0000};
  end

  // Stage 2 arithmetic: absolute value and saturation; zero is never negative since S[34]=0
  always_comb begin
    s_neg   = s1_s_q[34];
    s_abs   = s_neg ? (35'd0 - s1_s_q) : s1_s_q;
    mag_ovf = |s_abs[34:32];
    mag_sat = mag_ovf ? 32'hFFFF_FFFF : s_abs[31:0];
  end

  // Next-state for both pipeline stages; stage 2 holds while stalled by the consumer
  always_comb begin
    s1_valid_d  = in_fire || (s1_valid_q && !s2_adv);
    s1_s_d      = in_fire ? s_in : s1_s_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    res_ovf_d   = res_ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d     = {s_neg, mag_sat};
        res_ovf_d = mag_ovf;
      end
    end
  end

  // Saturating counter of delivered overflowed results; clear has priority
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (out_fire && res_ovf_q && !(&ovf_cnt_q)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; in-flight data is discarded on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_s_q      <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_s_q      <= s1_s_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      res_ovf_q   <= res_ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.res       = res_q;
  assign out_if.res_ovf   = res_ovf_q;
  assign ovf_cnt          = ovf_cnt_q;

endmodule

// File: tb/tb_sm_result_packer.sv
// Bench for sm_result_packer: directed steps plus random traffic checked against
// an arithmetic reference model and a queue-based scoreboard.
// Counter width is reduced so saturation is reachable in a short run.

module tb_sm_result_packer;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [CNT_W-1:0] ovf_cnt;

  sm_sum_if in_bus ();
  sm_res_if out_bus ();

  sm_result_packer #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_if   (in_bus.slave),
    .out_if  (out_bus.master),
    .ovf_clr (ovf_clr),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [33:0]      exp_q[$];
  logic [CNT_W-1:0] cnt_model = '0;
  int               xfers = 0;
  bit               mon_en = 1'b0;
  bit               rdy_mode = 1'b0;
  logic             rdy_force = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed value = cout*2^32 + sum - k*2^32, then sign/abs/saturate. Returns {ovf, sign, mag}.
  function automatic logic [33:0] model(input logic [31:0] s, input logic c, input logic [1:0] n);
    longint v;
    longint m;
    longint k;
    logic   sg;
    logic   ov;
    k  = (n == 2'd3) ? 64'sd2 : longint'({62'd0, n});
    v  = longint'({32'd0, s}) + (c ? 64'sd4294967296 : 64'sd0) - k * 64'sd4294967296;
    sg = (v < 0);
    m  = sg ? -v : v;
    ov = (m > 64'sd4294967295);
    if (ov) m = 64'sd4294967295;
    return {ov, sg, m[31:0]};
  endfunction

  // Consumer-ready driver
  always @(posedge clk) begin
    #2;
    out_bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Output monitor: scoreboard compare on each transfer, counter model tracking
  always @(negedge clk) begin : mon
    logic [33:0] e;
    bit          inc;
    if (mon_en) begin
      inc = 1'b0;
      chk("ovf_cnt", ovf_cnt, cnt_model);
      if (!rst_n) begin
        exp_q.delete();
        cnt_model = '0;
      end else begin
        if (out_bus.out_valid && out_bus.out_ready) begin
          xfers++;
          chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res", out_bus.res, e[32:0]);
            chk("res_ovf", out_bus.res_ovf, e[33]);
            inc = e[33];
          end
        end
        if (ovf_clr) cnt_model = '0;
        else if (inc && cnt_model != '1) cnt_model = cnt_model + 1'b1;
      end
    end
  end

  task automatic cyc(output bit acc);
    @(negedge clk);
    acc = in_bus.in_valid && in_bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input logic c, input logic [1:0] n);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    in_bus.in_valid = 1'b1;
    in_bus.sum = s;
    in_bus.cout = c;
    in_bus.neg_cnt = n;
    while (!acc && guard < 64) begin
      cyc(acc);
      guard++;
    end
    in_bus.in_valid = 1'b0;
    chk("send_accept", 64'(acc), 64'd1);
    if (acc) exp_q.push_back(model(s, c, n));
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard = 0;
    rdy_mode = 1'b0;
    rdy_force = 1'b1;
    while ((exp_q.size() != 0 || out_bus.out_valid) && guard < 100) begin
      cyc(acc);
      guard++;
    end
    chk("drain_done", 64'(exp_q.size() == 0 && !out_bus.out_valid), 64'd1);
  endtask

  task automatic wait_out(input string tag, input logic [32:0] r, input logic o);
    bit acc;
    int guard;
    guard = 0;
    while (!out_bus.out_valid && guard < 10) begin
      cyc(acc);
      guard++;
    end
    chk({tag, "_valid"}, out_bus.out_valid, 1'b1);
    chk({tag, "_res"}, out_bus.res, r);
    chk({tag, "_ovf"}, out_bus.res_ovf, o);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog timeout observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          acc;
    logic [31:0] it_s[4];
    logic        it_c[4];
    logic [1:0]  it_n[4];
    int          idx;
    int          x0;

    in_bus.in_valid = 1'b0;
    in_bus.sum = '0;
    in_bus.cout = 1'b0;
    in_bus.neg_cnt = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk("rst_out_valid", out_bus.out_valid, 1'b0);
    chk("rst_res", out_bus.res, 33'h0);
    chk("rst_res_ovf", out_bus.res_ovf, 1'b0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_in_ready", in_bus.in_ready, 1'b1);

    // 5+3 with latency check
    rdy_force = 1'b1;
    send(32'd8, 1'b0, 2'd0);
    chk("t1_lat1", out_bus.out_valid, 1'b0);
    cyc(acc);
    chk("t1_lat2", out_bus.out_valid, 1'b1);
    chk("t1_res", out_bus.res, {1'b0, 32'd8});
    chk("t1_ovf", out_bus.res_ovf, 1'b0);
    cyc(acc);

    // Negative result and exact zero
    send(32'hFFFF_FFFE, 1'b0, 2'd1);
    wait_out("t2_neg", {1'b1, 32'd2}, 1'b0);
    send(32'h0, 1'b1, 2'd1);
    wait_out("t2_zero", 33'h0, 1'b0);
    cyc(acc);

    // Positive and negative overflow, illegal neg_cnt=3 acts as 2
    chk("t3_cnt0", ovf_cnt, 0);
    send(32'h0, 1'b1, 2'd0);
    wait_out("t3_pos", {1'b0, 32'hFFFF_FFFF}, 1'b1);
    cyc(acc);
    chk("t3_cnt1", ovf_cnt, 1);
    send(32'd2, 1'b0, 2'd2);
    wait_out("t3_negovf", {1'b1, 32'hFFFF_FFFF}, 1'b1);
    send(32'd2, 1'b0, 2'd3);
    wait_out("t3_neg3", {1'b1, 32'hFFFF_FFFF}, 1'b1);
    cyc(acc);
    chk("t3_cnt3", ovf_cnt, 3);

    // Backpressure: 4 results with consumer stalled
    rdy_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      it_s[i] = $urandom;
      it_c[i] = 1'($urandom_range(0, 1));
      it_n[i] = 2'($urandom_range(0, 3));
    end
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      in_bus.in_valid = (idx < 4);
      if (idx < 4) begin
        in_bus.sum = it_s[idx];
        in_bus.cout = it_c[idx];
        in_bus.neg_cnt = it_n[idx];
      end
      cyc(acc);
      if (acc) begin
        exp_q.push_back(model(it_s[idx], it_c[idx], it_n[idx]));
        idx++;
      end
      if (out_bus.out_valid && exp_q.size() != 0) begin
        chk("t4_res_held", out_bus.res, exp_q[0][32:0]);
      end
    end
    chk("t4_accepted", idx, 2);
    chk("t4_in_ready", in_bus.in_ready, 1'b0);
    chk("t4_out_valid", out_bus.out_valid, 1'b1);
    x0 = xfers;
    rdy_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_bus.in_valid = (idx < 4);
      if (idx < 4) begin
        in_bus.sum = it_s[idx];
        in_bus.cout = it_c[idx];
        in_bus.neg_cnt = it_n[idx];
      end
      cyc(acc);
      if (acc) begin
        exp_q.push_back(model(it_s[idx], it_c[idx], it_n[idx]));
        idx++;
      end
    end
    in_bus.in_valid = 1'b0;
    chk("t4_all_sent", idx, 4);
    chk("t4_xfers", xfers - x0, 4);
    chk("t4_empty", out_bus.out_valid, 1'b0);

    // Random traffic with random consumer stalls and occasional clears
    rdy_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ovf_clr = ($urandom_range(0, 15) == 0);
      send($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    ovf_clr = 1'b0;
    drain();

    // Counter saturation
    rdy_mode = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send($urandom, 1'b1, 2'd0);
    end
    drain();
    chk("t5_sat", ovf_cnt, 8'hFF);
    send(32'h1234, 1'b1, 2'd0);
    drain();
    chk("t5_sat_hold", ovf_cnt, 8'hFF);

    // Clear coincident with an overflow transfer
    rdy_force = 1'b0;
    send(32'd5, 1'b1, 2'd0);
    cyc(acc);
    chk("t5_pending", out_bus.out_valid, 1'b1);
    ovf_clr = 1'b1;
    rdy_force = 1'b1;
    cyc(acc);
    ovf_clr = 1'b0;
    chk("t5_clr", ovf_cnt, 0);
    chk("t5_clr_xfer", out_bus.out_valid, 1'b0);
    send(32'd0, 1'b1, 2'd0);
    drain();
    chk("t5_cnt_after", ovf_cnt, 1);

    // Reset with two results in flight
    rdy_force = 1'b0;
    send(32'd7, 1'b0, 2'd0);
    send(32'd9, 1'b0, 2'd0);
    chk("t6_inflight", out_bus.out_valid, 1'b1);
    rst_n = 1'b0;
    cyc(acc);
    rst_n = 1'b1;
    chk("t6_out_valid", out_bus.out_valid, 1'b0);
    chk("t6_ovf_cnt", ovf_cnt, 0);
    chk("t6_in_ready", in_bus.in_ready, 1'b1);
    chk("t6_res", out_bus.res, 33'h0);
    x0 = xfers;
    rdy_force = 1'b1;
    repeat (5) cyc(acc);
    chk("t6_no_emit", xfers - x0, 0);
    chk("t6_idle", out_bus.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
